seq_div_8by4: RTL and testbench

//  - Sequential restoring divider: inverse operation of the team's 4x4 array multiplier.
//  - Divides an 8-bit dividend (product width) by a 4-bit divisor (operand width).
//  - Produces an 8-bit quotient and a 4-bit remainder, one quotient bit per clock.
//  - Controlled by a start/busy/done handshake; slots in beside the multiplier datapath.

---
 rtl/seq_div_8by4_if.sv | 26 ++
 rtl/seq_div_8by4.sv | 111 +++++++++++
 tb/tb_seq_div_8by4.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seq_div_8by4_if.sv
// Operand/result bundle for the sequential divider.
// Master drives the start request and operands; slave returns status and results.
// Carries no flow control of its own beyond start/busy/done.
interface seq_div_8by4_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_8by4.sv
// Restoring divider DW/VW: one quotient bit per clock, results registered on entering DONE.
// Latency: done DW+1 cycles after the accepting edge (1 cycle for divisor 0 with DIV_ZERO_FAST_EN).
// Backpressure: start is ignored while busy (CALC/DONE); operands are sampled only on acceptance.
module seq_div_8by4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          reset,
    seq_div_8by4_if.slave bus
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;   // dividend bits shift out the top, quotient bits shift in
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   rem_q, rem_d;       // partial remainder, one bit wider than the divisor
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rmo_q, rmo_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   r_shift;
    logic          qbit;
    logic [VW:0]   rem_nxt;
    logic [DW-1:0] shreg_nxt;

    // One restoring step: bring in the next dividend bit, subtract if it fits
    always_comb begin
        r_shift   = {rem_q[VW-1:0], shreg_q[DW-1]};
        qbit      = (r_shift >= {1'b0, dvs_q});
        rem_nxt   = qbit ? (r_shift - {1'b0, dvs_q}) : r_shift;
        shreg_nxt = {shreg_q[DW-2:0], qbit};
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmo_d   = rmo_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shreg_d = bus.dividend;
                    dvs_d   = bus.divisor;
                    rem_d   = '0;
                    cnt_d   = CW'(DW);
                    state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
                    // Divide by zero has a closed-form answer, so skip the iterations
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmo_d   = bus.dividend[VW-1:0];
                        dbz_d   = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                rem_d   = rem_nxt;
                shreg_d = shreg_nxt;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = shreg_nxt;
                    rmo_d   = rem_nxt[VW-1:0];
                    dbz_d   = (dvs_q == '0);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmo_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmo_q   <= rmo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div_8by4.sv
module tb_seq_div_8by4;
    localparam int DW = 8;
    localparam int VW = 4;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_div_8by4_if #(.DW(DW), .VW(VW)) bus ();
    seq_div_8by4 #(.DW(DW), .VW(VW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic int lat_of(input int b);
        return (FAST && b == 0) ? 1 : DW + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycles left until the operation retires, results by plain arithmetic
    int m_left = 0;
    int m_a = 0, m_b = 0;
    int m_q = 0, m_r = 0, m_z = 0;
    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_q = 0; m_r = 0; m_z = 0;
        end else begin
            if (m_left > 0) m_left--;
            else if (bus.start) begin
                m_a = int'(bus.dividend);
                m_b = int'(bus.divisor);
                m_left = lat_of(m_b);
            end
            if (m_left == 1) begin
                if (m_b == 0) begin
                    m_q = 255; m_r = m_a % 16; m_z = 1;
                end else begin
                    m_q = m_a / m_b; m_r = m_a % m_b; m_z = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",  32'(bus.busy),        32'(m_left > 0));
            chk("done",  32'(bus.done),        32'(m_left == 1));
            chk("quot",  32'(bus.quotient),    m_q);
            chk("rem",   32'(bus.remainder),   m_r);
            chk("dbz",   32'(bus.div_by_zero), m_z);
        end
    end

    // Directed op with hand-computed expectations; returns at the negedge showing done
    task automatic run_op(input int a, input int b, input int eq, input int er,
                          input int ez, input int elat, input string tag);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'(a); bus.divisor = 4'(b);
        n = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end while (!bus.done && n < 40);
        chk({tag, "_lat"},  n, elat);
        chk({tag, "_quot"}, 32'(bus.quotient), eq);
        chk({tag, "_rem"},  32'(bus.remainder), er);
        chk({tag, "_dbz"},  32'(bus.div_by_zero), ez);
    endtask

    // Back-to-back op with junk requests driven while busy
    task automatic do_op(input int a, input int b);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'(a); bus.divisor = 4'(b);
        repeat (lat_of(b)) begin
            @(negedge clk);
            bus.start    = 1'($urandom_range(0, 1));
            bus.dividend = 8'($urandom);
            bus.divisor  = 4'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int dones, gaps;
        reset = 1'b1; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_quot", 32'(bus.quotient), 0);
        chk("rst_rem",  32'(bus.remainder), 0);
        chk("rst_dbz",  32'(bus.div_by_zero), 0);
        reset = 1'b0;

        run_op(200, 7, 28, 4, 0, 9, "t1");
        run_op(255, 1, 255, 0, 0, 9, "t2a");
        run_op(5, 9, 0, 5, 0, 9, "t2b");
        run_op(143, 0, 255, 15, 1, FAST ? 1 : 9, "t3");

        // Second request during CALC must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd3;
        @(negedge clk); bus.start = 1'b0;
        dones = 0; gaps = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) dones++;
            if (dones == 0 && !bus.busy) gaps++;
            @(negedge clk);
        end
        chk("t4_dones", dones, 1);
        chk("t4_busy_gaps", gaps, 0);
        chk("t4_quot", 32'(bus.quotient), 28);
        chk("t4_rem",  32'(bus.remainder), 4);

        // Reset during the 4th CALC cycle aborts the operation
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_done", 32'(bus.done), 0);
        chk("t5_quot", 32'(bus.quotient), 0);
        chk("t5_rem",  32'(bus.remainder), 0);
        chk("t5_dbz",  32'(bus.div_by_zero), 0);
        reset = 1'b0;
        run_op(100, 10, 10, 0, 0, 9, "t5b");

        // Exhaustive sweep, back-to-back
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                do_op(a, b);
        @(negedge clk); bus.start = 1'b0;
        repeat (12) @(negedge clk);

        // Random requests with occasional resets
        repeat (3000) begin
            @(negedge clk);
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.dividend = 8'($urandom);
            bus.divisor  = 4'($urandom);
            reset        = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
